clk_en_rst_gen: RTL and testbench

- Parametrised successor to the single fixed divide-by-8 clock/reset generator.
- Runs entirely in the fast DCM output domain (clk).
- Produces NUM_DIV independent clock-enable pulse trains and divided square waves, each with a runtime-programmable divisor.
- Generates a stretched system reset that is held until the DCM reports lock and channel 0 has produced RST_CYCLES enables; reset re-asserts whenever lock drops.

---
 rtl/clk_en_rst_gen.sv | 140 ++++++++++++++
 tb/tb_clk_en_rst_gen.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/clk_en_rst_gen.sv
// Parametrised clock-enable / divided-clock / stretched-reset generator in the DCM clk domain.
// Define CLK_EN_RST_GEN_LOCK_SYNC_EN to pass lock through a 2-flop synchroniser.
module clk_en_rst_gen #(
    parameter int unsigned                 NUM_DIV    = 2,
    parameter int unsigned                 DIV_W      = 8,
    parameter logic [NUM_DIV*DIV_W-1:0]    DIV_INIT   = {8'd7, 8'd7},
    parameter int unsigned                 RST_CYCLES = 127
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               lock,
    input  logic               wr_en,
    input  logic [2:0]         wr_sel,
    input  logic [DIV_W-1:0]   wr_data,
    output logic [NUM_DIV-1:0] ce,
    output logic [NUM_DIV-1:0] div_clk,
    output logic               rst_out,
    output logic [1:0]         state
);

    localparam int unsigned SW = $clog2(RST_CYCLES + 1);
    localparam logic [SW-1:0] STR_LAST = SW'(RST_CYCLES - 1);
    localparam logic [SW-1:0] STR_MAX  = SW'(RST_CYCLES);

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_STRETCH   = 2'd1,
        S_RUN       = 2'd2
    } state_e;

    logic [DIV_W-1:0]   cnt_q [NUM_DIV];
    logic [DIV_W-1:0]   cnt_d [NUM_DIV];
    logic [DIV_W-1:0]   act_q [NUM_DIV];
    logic [DIV_W-1:0]   act_d [NUM_DIV];
    logic [DIV_W-1:0]   shd_q [NUM_DIV];
    logic [DIV_W-1:0]   shd_d [NUM_DIV];
    logic [NUM_DIV-1:0] ce_q, ce_d;
    logic [NUM_DIV-1:0] dclk_q, dclk_d;

    state_e          state_q, state_d;
    logic [SW-1:0]   str_q, str_d;
    logic            rst_out_q, rst_out_d;
    logic            lock_q;

`ifdef CLK_EN_RST_GEN_LOCK_SYNC_EN
    logic lock_s1_q, lock_s2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_s1_q <= 1'b0;
            lock_s2_q <= 1'b0;
        end else begin
            lock_s1_q <= lock;
            lock_s2_q <= lock_s1_q;
        end
    end

    assign lock_q = lock_s2_q;
`else
    assign lock_q = lock;
`endif

    // Shadow reaches the active divisor only on a wrap, so periods are never cut short.
    always_comb begin
        for (int unsigned i = 0; i < NUM_DIV; i++) begin
            cnt_d[i]  = (cnt_q[i] == act_q[i]) ? '0 : cnt_q[i] + DIV_W'(1);
            act_d[i]  = (cnt_q[i] == act_q[i]) ? shd_q[i] : act_q[i];
            shd_d[i]  = (wr_en && (wr_sel == 3'(i))) ? wr_data : shd_q[i];
            ce_d[i]   = (cnt_q[i] == act_q[i]);
            dclk_d[i] = dclk_q[i] ^ ce_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_DIV; i++) begin
                cnt_q[i] <= '0;
                act_q[i] <= DIV_INIT[i*DIV_W +: DIV_W];
                shd_q[i] <= DIV_INIT[i*DIV_W +: DIV_W];
            end
            ce_q   <= '0;
            dclk_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_DIV; i++) begin
                cnt_q[i] <= cnt_d[i];
                act_q[i] <= act_d[i];
                shd_q[i] <= shd_d[i];
            end
            ce_q   <= ce_d;
            dclk_q <= dclk_d;
        end
    end

    always_comb begin
        state_d = state_q;
        str_d   = str_q;
        case (state_q)
            S_WAIT_LOCK: begin
                str_d = '0;
                if (lock_q) state_d = S_STRETCH;
            end
            S_STRETCH: begin
                if (ce_q[0]) begin
                    if (str_q >= STR_LAST) begin
                        str_d   = STR_MAX;
                        state_d = S_RUN;
                    end else begin
                        str_d = str_q + SW'(1);
                    end
                end
            end
            S_RUN: ;
            default: state_d = S_WAIT_LOCK;
        endcase
        // Loss of lock overrides everything and restarts the stretch from zero.
        if (!lock_q) begin
            state_d = S_WAIT_LOCK;
            str_d   = '0;
        end
        rst_out_d = (state_d != S_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_WAIT_LOCK;
            str_q     <= '0;
            rst_out_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            str_q     <= str_d;
            rst_out_q <= rst_out_d;
        end
    end

    assign ce      = ce_q;
    assign div_clk = dclk_q;
    assign rst_out = rst_out_q;
    assign state   = state_q;

endmodule

// File: tb/tb_clk_en_rst_gen.sv
// Directed bench for clk_en_rst_gen: dividers, divisor writes, reset stretch, lock handling.
module tb_clk_en_rst_gen;

`ifdef CLK_EN_RST_GEN_LOCK_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst, lock, wr_en;
    logic [2:0] wr_sel;
    logic [7:0] wr_data;
    logic [1:0] ce, div_clk;
    logic       rst_out;
    logic [1:0] state;

    int n_cmp = 0;
    int n_err = 0;
    int k = 0;
    int fall_k;

    clk_en_rst_gen #(
        .NUM_DIV    (2),
        .DIV_W      (8),
        .DIV_INIT   ({8'd7, 8'd7}),
        .RST_CYCLES (127)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .lock    (lock),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_data (wr_data),
        .ce      (ce),
        .div_clk (div_clk),
        .rst_out (rst_out),
        .state   (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s at edge %0d: got %0d expected %0d", tag, k, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    // Channel 0 with D=7 from release: ce after every 8th edge, div_clk toggles one edge later.
    task automatic chk_ch0_d7();
        chk("ce0_d7",  32'(ce[0]),      32'(k % 8 == 0));
        chk("div0_d7", 32'(div_clk[0]), 32'(((k - 1) / 8) % 2));
    endtask

    task automatic wait_fall();
        fall_k = -1;
        for (int n = 0; n < 1200; n++) begin
            tick();
            chk_ch0_d7();
            if (!rst_out) begin
                fall_k = k;
                break;
            end
        end
    endtask

    initial begin
        rst = 1'b1; lock = 1'b0; wr_en = 1'b0; wr_sel = 3'd0; wr_data = 8'd0;

        // 1: reset state, then free-running dividers while unlocked
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_rst_out", 32'(rst_out), 32'd1);
            chk("rst_state",   32'(state),   32'd0);
            chk("rst_ce",      32'(ce),      32'd0);
            chk("rst_div",     32'(div_clk), 32'd0);
        end
        rst = 1'b0;
        k = 0;
        repeat (24) begin
            tick();
            chk_ch0_d7();
            chk("ce1_d7",      32'(ce[1]),   32'(k % 8 == 0));
            chk("wait_rstout", 32'(rst_out), 32'd1);
            chk("wait_state",  32'(state),   32'd0);
        end

        // 2: lock rises, stretch of 127 channel-0 enables
        lock = 1'b1;
        for (int i = 1; i <= LAT; i++) begin
            tick();
            chk("lock_state", 32'(state), (i == LAT) ? 32'd1 : 32'd0);
        end
        wait_fall();
        chk("fall_edge_1", 32'(fall_k), 32'd1041);
        chk("run_state",   32'(state),  32'd2);

        // 3: one-cycle lock drop in RUN, full restart of the stretch
        repeat (3) tick();
        chk("run_rstout", 32'(rst_out), 32'd0);
        lock = 1'b0;
        tick();
        lock = 1'b1;
        repeat (LAT - 1) tick();
        chk("drop_state",  32'(state),   32'd0);
        chk("drop_rstout", 32'(rst_out), 32'd1);
        tick();
        chk("relock_state", 32'(state), 32'd1);
        wait_fall();
        chk("fall_edge_2", 32'(fall_k), 32'd2057);

        // 4: ch1 divisor 7 -> 2 written while counter1 = 3
        while (k < 2059) tick();
        wr_en = 1'b1; wr_sel = 3'd1; wr_data = 8'd2;
        tick();
        wr_en = 1'b0;
        chk("ce1_w", 32'(ce[1]), 32'd0);
        while (k < 2080) begin
            tick();
            chk_ch0_d7();
            chk("ce1_d2", 32'(ce[1]), 32'(k >= 2064 && (k - 2064) % 3 == 0));
        end

        // 5: out-of-range write ignored, then ch0 divisor 0
        wr_en = 1'b1; wr_sel = 3'd5; wr_data = 8'd0;
        tick();
        wr_sel = 3'd0;
        tick();
        wr_en = 1'b0;
        while (k < 2100) begin
            if (k > 2082) tick();
            chk("ce1_keep", 32'(ce[1]), 32'((k - 2064) % 3 == 0));
            chk("ce0_d0",   32'(ce[0]), (k < 2088) ? 32'(k % 8 == 0) : 32'd1);
            chk("div0_d0",  32'(div_clk[0]), (k < 2088) ? 32'(((k - 1) / 8) % 2) : 32'((k - 2088) % 2));
            if (k <= 2082) tick();
        end

        // 6: lock latency and single-cycle lock pulse
        lock = 1'b0;
        for (int i = 1; i <= LAT; i++) begin
            tick();
            chk("unlock_state", 32'(state), (i == LAT) ? 32'd0 : 32'd2);
        end
        while (k < 2110) tick();
        lock = 1'b1;
        tick();
        lock = 1'b0;
        chk("pulse_state", 32'(state), (LAT == 1) ? 32'd1 : 32'd0);
        while (k < 2110 + LAT) begin
            tick();
            chk("pulse_state", 32'(state), (k == 2110 + LAT) ? 32'd1 : 32'd0);
        end
        tick();
        chk("pulse_back_state",  32'(state),   32'd0);
        chk("pulse_back_rstout", 32'(rst_out), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
